// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/odd parity/stop,
// then samples the device ACK. Lines are driven through open-drain enables.
`timescale 1ns / 1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StData, StParity, StStop, StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic            clk_prev_q, clk_prev_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            parity_q, parity_d, err_q, err_d;
  logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic            tx_ready_q, tx_ready_d, busy_q, busy_d;
  logic            done_q, done_d, ack_err_q, ack_err_d, timeout_q, timeout_d;
  logic            fall;

  always_comb begin
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_sync_q[1];
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    parity_d    = parity_q;
    err_d       = err_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    ack_err_d   = 1'b0;
    timeout_d   = 1'b0;
    fall        = clk_prev_q & ~clk_sync_q[1];

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          byte_d    = tx_data;
          parity_d  = ~^tx_data;
          err_d     = 1'b0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = (InhLast == '0);
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        to_cnt_d = '0;
        if (inh_cnt_q == InhLast) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = StStart;
        end else begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
          // Data goes low for the last inhibit cycle so the start bit is set up before release.
          data_oe_d = (inh_cnt_d == InhLast);
        end
      end
      StStart: begin
        if (fall) begin
          data_oe_d = ~byte_q[0];
          idx_d     = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (fall) begin
          if (idx_q != 3'd7) begin
            idx_d     = idx_q + 3'd1;
            data_oe_d = ~byte_q[idx_q + 3'd1];
          end else begin
            data_oe_d = ~parity_q;
            state_d   = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          data_oe_d = 1'b0;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          err_d   = data_sync_q[1];
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_sync_q[1] && data_sync_q[1]) begin
          done_d    = ~err_q;
          ack_err_d = err_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The device-clocked phase is bounded; expiry wins over any fall in the same cycle.
    if (state_q != StIdle && state_q != StInhibit) begin
      if (to_cnt_q == ToLast) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b1;
        state_d   = StIdle;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end

    busy_d     = (state_d != StIdle);
    tx_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      idx_q       <= 3'd0;
      byte_q      <= 8'h00;
      parity_q    <= 1'b0;
      err_q       <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      err_q       <= err_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// checks captured bits against a scoreboard of expected frames.
`timescale 1ns / 1ps
module tb_ps2_host_tx;

  localparam int unsigned InhibitCycles = 3000;
  localparam int unsigned TimeoutCycles = 5000;
  localparam int          HalfNs        = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_err, timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_n = 0, err_n = 0, tmo_n = 0, acc_n = 0;
  logic [10:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && tx_valid && tx_ready) acc_n <= acc_n + 1;
  always @(negedge clk) begin
    done_n <= done_n + (done === 1'b1 ? 1 : 0);
    err_n  <= err_n + (ack_err === 1'b1 ? 1 : 0);
    tmo_n  <= tmo_n + (timeout === 1'b1 ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int half_ns(input bit jitter);
    return HalfNs + (jitter ? int'($urandom_range(0, 40)) : 0);
  endfunction

  // Frame layout: bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop.
  task automatic send_byte(input logic [7:0] d, input logic par);
    bit acc = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    sb_q.push_back({1'b1, par, d, 1'b0});
    for (int i = 0; i < 4 * InhibitCycles + TimeoutCycles && !acc; i++) begin
      if (tx_ready === 1'b1) acc = 1;
      else @(negedge clk);
    end
    check("accept_seen", 32'(acc), 32'd1);
    if (acc) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dev_frame(input int n_falls, input logic ack_one, input bit jitter,
                           output int inh_len, output int start_cyc);
    logic [10:0] got, exp_bits, mask;
    bit seen;
    int n;
    got = '0;
    inh_len = 0;
    start_cyc = 0;
    seen = 0;
    for (int i = 0; i < 4 * InhibitCycles && !seen; i++) begin
      @(negedge clk);
      seen = (ps2_clk_oe === 1'b1);
    end
    check("inhibit_seen", 32'(seen), 32'd1);
    if (seen) begin
      inh_len = 1;
      for (int i = 0; i < 2 * InhibitCycles; i++) begin
        @(negedge clk);
        if (ps2_clk_oe !== 1'b1) break;
        inh_len++;
      end
      start_cyc = cyc;
      check("start_bit_drive", 32'(ps2_data_oe), 32'd1);
      #(half_ns(jitter));
      got[0] = ps2_data_in;
      for (int k = 1; k <= n_falls; k++) begin
        #(half_ns(jitter));
        dev_clk_low = 1'b1;
        #(half_ns(jitter));
        if (k <= 10) got[k] = ps2_data_in;
        dev_clk_low = 1'b0;
        if (k == 10) dev_data_low = ~ack_one;
      end
      #(half_ns(jitter));
      dev_data_low = 1'b0;
    end
    n = (n_falls < 10) ? n_falls : 10;
    mask = 11'((32'd1 << (n + 1)) - 32'd1);
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      exp_bits = sb_q.pop_front();
      check("frame_bits", 32'(got & mask), 32'(exp_bits & mask));
    end
  endtask

  task automatic wait_ready(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (tx_ready === 1'b1);
    end
    check("ready_return", 32'(ok), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int inh, sc, d0, e0, t0, a0, tc;
    bit tseen;
    #1 rst = 1'b1;
    #1;
    check("rst_async_ready", 32'(tx_ready), 32'd1);
    check("rst_async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, ack_err, timeout}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED: 6 ones, odd parity bit 1, ACK 0.
    d0 = done_n; e0 = err_n; t0 = tmo_n;
    fork
      begin send_byte(8'hED, 1'b1); tx_valid = 1'b0; end
      begin dev_frame(11, 1'b0, 1'b0, inh, sc); end
    join
    wait_ready(2000);
    check("inhibit_len", 32'(inh), 32'(InhibitCycles));
    check("ed_done", 32'(done_n - d0), 32'd1);
    check("ed_no_err", 32'((err_n - e0) + (tmo_n - t0)), 32'd0);

    // Back-to-back with tx_valid held high.
    d0 = done_n;
    fork
      begin
        send_byte(8'hF4, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tx_valid = 1'b0;
      end
      begin
        dev_frame(11, 1'b0, 1'b0, inh, sc);
        dev_frame(11, 1'b0, 1'b0, inh, sc);
        dev_frame(11, 1'b0, 1'b0, inh, sc);
      end
    join
    wait_ready(2000);
    check("b2b_done", 32'(done_n - d0), 32'd3);

    // Device refuses with ACK=1.
    d0 = done_n; e0 = err_n;
    fork
      begin send_byte(8'hFF, 1'b1); tx_valid = 1'b0; end
      begin dev_frame(11, 1'b1, 1'b0, inh, sc); end
    join
    wait_ready(2000);
    check("nack_err", 32'(err_n - e0), 32'd1);
    check("nack_no_done", 32'(done_n - d0), 32'd0);
    check("nack_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

    // Device stops after 4 falls.
    d0 = done_n; e0 = err_n; t0 = tmo_n;
    fork
      begin send_byte(8'hA5, 1'b1); tx_valid = 1'b0; end
      begin dev_frame(4, 1'b0, 1'b0, inh, sc); end
    join
    tseen = 0;
    tc = 0;
    for (int i = 0; i < int'(TimeoutCycles) + 200 && !tseen; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin tseen = 1; tc = cyc; end
    end
    check("timeout_seen", 32'(tseen), 32'd1);
    check("timeout_latency", 32'(tc - sc), 32'(TimeoutCycles));
    @(negedge clk);
    check("timeout_released", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
    check("timeout_ready", 32'(tx_ready), 32'd1);
    check("timeout_once", 32'(tmo_n - t0), 32'd1);
    check("timeout_no_other", 32'((done_n - d0) + (err_n - e0)), 32'd0);

    // Jittered device clock with stray requests while busy; one frame only.
    d0 = done_n; a0 = acc_n;
    fork
      begin
        send_byte(8'h3C, 1'b1);
        tx_valid = 1'b0;
        for (int p = 0; p < 5; p++) begin
          repeat (600) @(negedge clk);
          if (tx_ready === 1'b0) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
          end
        end
      end
      begin dev_frame(11, 1'b0, 1'b1, inh, sc); end
    join
    wait_ready(2000);
    check("jitter_done", 32'(done_n - d0), 32'd1);
    check("jitter_one_accept", 32'(acc_n - a0), 32'd1);
    repeat (100) @(negedge clk);
    check("jitter_no_extra_frame", 32'({ps2_clk_oe, busy}), 32'd0);

    // Reset during DATA with idx=3 (bit3 of 0xF0 is 0, so data is pulled low).
    fork
      begin send_byte(8'hF0, 1'b1); tx_valid = 1'b0; end
      begin dev_frame(4, 1'b0, 1'b0, inh, sc); end
    join
    @(negedge clk);
    check("mid_data_low", 32'(ps2_data_oe), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    d0 = done_n; e0 = err_n; t0 = tmo_n;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("rst_mid_no_pulse", 32'((done_n - d0) + (err_n - e0) + (tmo_n - t0)), 32'd0);
    check("rst_mid_idle", 32'({busy, tx_ready}), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
